// File: rtl/rbus_vga_eve_ctrl_pkg.sv
// Shared types and VGA event command codes for the ring-bus VGA event initiator
// and the device-side block that decodes the same commands.
package rbus_vga_eve_ctrl_pkg;

   localparam logic [7:0] CMD_VGA_SET_BASE     = 8'h20;
   localparam logic [7:0] CMD_VGA_SET_PH_WIDTH = 8'h21;
   localparam logic [7:0] CMD_VGA_SET_LO_WIDTH = 8'h22;
   localparam logic [7:0] CMD_VGA_SET_LO_HEIGHT= 8'h23;
   localparam logic [7:0] CMD_VGA_SET_MODE     = 8'h24;
   localparam logic [7:0] CMD_VGA_SET_TEXT     = 8'h25;
   localparam logic [7:0] CMD_VGA_PUT_CHAR     = 8'h26;
   localparam logic [7:0] CMD_VGA_SET_H_POL    = 8'h27;
   localparam logic [7:0] CMD_VGA_SET_V_POL    = 8'h28;

   localparam logic [2:0] CFG_LAST_IDX = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      CFG,
      CHR
   } state_t;

   typedef struct packed {
      logic [38:0] base_addr;
      logic [15:0] ph_width;
      logic [15:0] lo_width;
      logic [15:0] lo_height;
      logic [1:0]  mode;
      logic        text_ena;
      logic        h_pol;
      logic        v_pol;
   } vga_cfg_t;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [39:0] ptr;
   } vga_eve_t;

   // Burst slot -> event; the device expects polarities before the text enable.
   function automatic vga_eve_t cfg_event(input vga_cfg_t c, input logic [2:0] idx);
      vga_eve_t e;
      case (idx)
         3'd0: begin e.cmd = CMD_VGA_SET_BASE;      e.ptr = {1'b0, c.base_addr};  end
         3'd1: begin e.cmd = CMD_VGA_SET_PH_WIDTH;  e.ptr = {24'd0, c.ph_width};  end
         3'd2: begin e.cmd = CMD_VGA_SET_LO_WIDTH;  e.ptr = {24'd0, c.lo_width};  end
         3'd3: begin e.cmd = CMD_VGA_SET_LO_HEIGHT; e.ptr = {24'd0, c.lo_height}; end
         3'd4: begin e.cmd = CMD_VGA_SET_MODE;      e.ptr = {38'd0, c.mode};      end
         3'd5: begin e.cmd = CMD_VGA_SET_H_POL;     e.ptr = {39'd0, c.h_pol};     end
         3'd6: begin e.cmd = CMD_VGA_SET_V_POL;     e.ptr = {39'd0, c.v_pol};     end
         default: begin e.cmd = CMD_VGA_SET_TEXT;   e.ptr = {39'd0, c.text_ena};  end
      endcase
      return e;
   endfunction

endpackage

// File: rtl/rbus_vga_chr_fifo.sv
// Character FIFO with registered full/empty flags; a push while full is taken
// only when a pop frees the slot in the same cycle.
module rbus_vga_chr_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg, count_next;
   logic          full_reg, empty_reg;
   logic          do_push, do_pop;

   assign do_pop  = pop && !empty_reg;
   assign do_push = push && (!full_reg || do_pop);

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop)
         count_next = count_reg + 1'b1;
      else if (!do_push && do_pop)
         count_next = count_reg - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_next;
         full_reg  <= (count_next == DEPTH_CNT);
         empty_reg <= (count_next == '0);
      end
   end

   // Storage has no reset; contents are only visible once counted in.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
   assign full  = full_reg;
   assign empty = empty_reg;

endmodule

// File: rtl/rbus_vga_eve_ctrl.sv
// Ring-bus event initiator for the VGA device: replays a snapshotted display
// configuration as a SET_* burst and drains a character FIFO as PUT_CHAR events.
module rbus_vga_eve_ctrl
   import rbus_vga_eve_ctrl_pkg::*;
#(
   parameter logic [7:0] DEV_ID      = 8'h00,
   parameter int         CHAR_DEPTH  = 16,
   parameter int         ACK_TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [38:0] cfg_base_addr,
   input  logic [15:0] cfg_ph_width,
   input  logic [15:0] cfg_lo_width,
   input  logic [15:0] cfg_lo_height,
   input  logic [1:0]  cfg_mode,
   input  logic        cfg_text_ena,
   input  logic        cfg_h_pol,
   input  logic        cfg_v_pol,
   input  logic        cfg_apply,
   output logic        cfg_busy,
   input  logic        chr_stb,
   input  logic [7:0]  chr_data,
   output logic        chr_rdy,
   output logic        d2r_eve_stb,
   output logic [7:0]  d2r_eve_cmd,
   output logic [7:0]  d2r_eve_dev,
   output logic [39:0] d2r_eve_ptr,
   input  logic        d2r_eve_ack,
   output logic        timeout_err,
   input  logic        err_clr
);
   localparam int          TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam bit          TO_EN   = (ACK_TIMEOUT != 0);

   state_t      state_reg, state_next;
   logic [2:0]  idx_reg, idx_next;
   vga_cfg_t    snap_reg, snap_next, cfg_in;
   logic        pending_reg, pending_next;
   logic        stb_reg, stb_next;
   logic [7:0]  cmd_reg, cmd_next;
   logic [39:0] ptr_reg, ptr_next;
   logic        busy_reg;
   logic        terr_reg;
   logic [TW-1:0] wait_cnt_reg;
   logic        timeout_hit, done, chr_done;
   vga_eve_t    ev;

   logic [7:0]                    fifo_head;
   logic [$clog2(CHAR_DEPTH):0]   fifo_count;
   logic                          fifo_full, fifo_empty, fifo_pop;

   rbus_vga_chr_fifo #(
      .DEPTH (CHAR_DEPTH),
      .W     (8)
   ) u_chr_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (chr_stb),
      .push_data (chr_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      cfg_in.base_addr = cfg_base_addr;
      cfg_in.ph_width  = cfg_ph_width;
      cfg_in.lo_width  = cfg_lo_width;
      cfg_in.lo_height = cfg_lo_height;
      cfg_in.mode      = cfg_mode;
      cfg_in.text_ena  = cfg_text_ena;
      cfg_in.h_pol     = cfg_h_pol;
      cfg_in.v_pol     = cfg_v_pol;
   end

   // A stalled event is abandoned on its ACK_TIMEOUT-th unacknowledged cycle.
   assign timeout_hit = TO_EN && stb_reg && !d2r_eve_ack && (wait_cnt_reg == TO_LAST);
   assign done        = stb_reg && (d2r_eve_ack || timeout_hit);
   assign chr_done    = (state_reg == CHR) && done;
   assign fifo_pop    = chr_done && !fifo_empty;

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      snap_next    = snap_reg;
      pending_next = pending_reg | cfg_apply;
      stb_next     = stb_reg;
      cmd_next     = cmd_reg;
      ptr_next     = ptr_reg;
      ev           = '0;
      case (state_reg)
         IDLE: begin
            if (pending_reg || cfg_apply) begin
               snap_next    = cfg_in;
               ev           = cfg_event(cfg_in, 3'd0);
               stb_next     = 1'b1;
               cmd_next     = ev.cmd;
               ptr_next     = ev.ptr;
               idx_next     = 3'd0;
               pending_next = 1'b0;
               state_next   = CFG;
            end else if (fifo_count != '0) begin
               stb_next   = 1'b1;
               cmd_next   = CMD_VGA_PUT_CHAR;
               ptr_next   = {32'd0, fifo_head};
               state_next = CHR;
            end
         end
         CFG: begin
            if (done) begin
               if (idx_reg == CFG_LAST_IDX) begin
                  stb_next   = 1'b0;
                  state_next = IDLE;
               end else begin
                  idx_next = idx_reg + 3'd1;
                  if (timeout_hit) begin
                     stb_next = 1'b0;
                  end else begin
                     ev       = cfg_event(snap_reg, idx_reg + 3'd1);
                     stb_next = 1'b1;
                     cmd_next = ev.cmd;
                     ptr_next = ev.ptr;
                  end
               end
            end else if (!stb_reg) begin
               // Gap cycle after a timed-out slot: issue the current slot.
               ev       = cfg_event(snap_reg, idx_reg);
               stb_next = 1'b1;
               cmd_next = ev.cmd;
               ptr_next = ev.ptr;
            end
         end
         CHR: begin
            if (done) begin
               stb_next   = 1'b0;
               state_next = IDLE;
            end
         end
         default: begin
            stb_next   = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         idx_reg      <= 3'd0;
         snap_reg     <= '0;
         pending_reg  <= 1'b0;
         stb_reg      <= 1'b0;
         cmd_reg      <= 8'd0;
         ptr_reg      <= 40'd0;
         busy_reg     <= 1'b0;
         terr_reg     <= 1'b0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         snap_reg    <= snap_next;
         pending_reg <= pending_next;
         stb_reg     <= stb_next;
         cmd_reg     <= cmd_next;
         ptr_reg     <= ptr_next;
         busy_reg    <= (state_next == CFG) | pending_next;
         if (timeout_hit)
            terr_reg <= 1'b1;
         else if (err_clr)
            terr_reg <= 1'b0;
         if (stb_reg && !d2r_eve_ack && !timeout_hit)
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
         else
            wait_cnt_reg <= '0;
      end
   end

   assign cfg_busy    = busy_reg;
   assign chr_rdy     = !fifo_full;
   assign d2r_eve_stb = stb_reg;
   assign d2r_eve_cmd = cmd_reg;
   assign d2r_eve_dev = DEV_ID;
   assign d2r_eve_ptr = ptr_reg;
   assign timeout_err = terr_reg;

endmodule
